// File: rtl/imem_loader.sv
// Streams program words into instruction memory and holds the processor in reset until the load succeeds.
// Optional end-of-stream checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] CHECK = 3'd2;
`endif
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_count;
  logic              r_in_ready;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic              r_cpu_reset;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       r_sum;
`endif

  logic [2:0] w_next_state;
  logic       w_clear;
  logic       w_accept;
  logic       w_load_accept;
  logic       w_last_addr;

  assign w_accept      = in_valid & r_in_ready;
  assign w_load_accept = w_accept & (r_state == LOAD);
  assign w_last_addr   = (r_count == {ADDR_W{1'b1}});

  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start) begin
          w_next_state = LOAD;
          w_clear      = 1'b1;
        end
      end
      LOAD: begin
        if (w_accept) begin
          if (in_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            w_next_state = CHECK;
`else
            w_next_state = DONE;
`endif
          end else if (w_last_addr) begin
            w_next_state = ERR;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (w_accept) begin
          w_next_state = (in_data == r_sum) ? DONE : ERR;
        end
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_in_ready  <= (w_next_state == LOAD) || (w_next_state == CHECK);
      r_busy      <= (w_next_state == LOAD) || (w_next_state == CHECK);
`else
      r_in_ready  <= (w_next_state == LOAD);
      r_busy      <= (w_next_state == LOAD);
`endif
      r_cpu_reset <= (w_next_state != DONE);
      r_done      <= (w_next_state == DONE);
      r_err       <= (w_next_state == ERR);
    end
  end

  // The counter saturates at the top address so an overflow never wraps back onto word 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wd    <= '0;
    end else begin
      r_we <= w_load_accept;
      if (w_load_accept) begin
        r_addr <= r_count;
        r_wd   <= in_data;
      end
      if (w_clear) begin
        r_count <= '0;
      end else if (w_load_accept && !w_last_addr) begin
        r_count <= r_count + ADDR_W'(1);
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sum <= '0;
    end else if (w_clear) begin
      r_sum <= '0;
    end else if (w_load_accept) begin
      r_sum <= r_sum + in_data;
    end
  end
`endif

  assign in_ready  = r_in_ready;
  assign imem_we   = r_we;
  assign imem_addr = r_addr;
  assign imem_wd   = r_wd;
  assign cpu_reset = r_cpu_reset;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected memory writes, a negedge monitor checks them.
// Checksum scenarios run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int AW = 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    int            cyc;
  } writeT;

  logic          clk;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [31:0]   in_data;
  logic          in_last;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          err;

  int assertCount = 0;
  int failCount   = 0;
  int cycleCount  = 0;
  logic [AW-1:0] expAddr;
  writeT expQ[$];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wd(imem_wd), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every write strobe must match the oldest expected write, including the cycle it lands in.
  always @(negedge clk) begin
    if (imem_we) begin
      writeT w;
      assertCount++;
      if (expQ.size() == 0) begin
        failCount++;
        $display("[TB] FAIL spurious_write: got addr=%0d data=%h, required no write", imem_addr, imem_wd);
      end else begin
        w = expQ.pop_front();
        if (imem_addr !== w.addr || imem_wd !== w.data || cycleCount != w.cyc) begin
          failCount++;
          $display("[TB] FAIL mem_write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                   imem_addr, imem_wd, cycleCount, w.addr, w.data, w.cyc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string name, input logic expReady, input logic expCpuReset,
                             input logic expBusy, input logic expDone, input logic expErr);
    checkOutput(name, {27'd0, in_ready, cpu_reset, busy, done, err},
                {27'd0, expReady, expCpuReset, expBusy, expDone, expErr});
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that carried the start pulse.
  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expAddr = '0;
  endtask

  task automatic applyStimulus(input logic [31:0] data, input logic last, input logic expWrite);
    int waitCycles = 0;
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    while (!in_ready && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!in_ready) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles, required 1");
    end else if (expWrite) begin
      expQ.push_back('{addr: expAddr, data: data, cyc: cycleCount + 1});
      expAddr++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    expAddr  = '0;
    #23;
    checkStatus("reset_status", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_addr", {30'd0, imem_addr}, 32'd0);
    checkOutput("reset_wd", imem_wd, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // No start: processor stays in reset, loader refuses data.
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput("idle_hold", {29'd0, cpu_reset, in_ready, imem_we}, {29'd0, 3'b100});
    end
    in_valid = 1'b0;

    // Back-to-back program load.
    pulseStart();
    checkStatus("load_status", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h20020005, 1'b0, 1'b1);
    applyStimulus(32'h2003000C, 1'b0, 1'b1);
    applyStimulus(32'h2067FFF7, 1'b0, 1'b1);
    applyStimulus(32'h00E22025, 1'b1, 1'b1);
    checkStatus("done_status", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idleCycles(3);
    checkOutput("hold_addr", {30'd0, imem_addr}, 32'd3);
    checkOutput("hold_wd", imem_wd, 32'h00E22025);

    // Restart from DONE re-asserts cpu_reset; stall with garbage, in_last and start must be ignored.
    pulseStart();
    checkStatus("restart_status", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h20020005, 1'b0, 1'b1);
    applyStimulus(32'h2003000C, 1'b0, 1'b1);
    in_data = 32'hDEADBEEF;
    in_last = 1'b1;
    start   = 1'b1;
    idleCycles(1);
    start = 1'b0;
    idleCycles(2);
    in_last = 1'b0;
    checkStatus("stall_status", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h2067FFF7, 1'b0, 1'b1);
    applyStimulus(32'h00E22025, 1'b1, 1'b1);
    checkStatus("done2_status", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Overflow: four words fill the memory, the fifth is refused.
    pulseStart();
    applyStimulus(32'h11111111, 1'b0, 1'b1);
    applyStimulus(32'h22222222, 1'b0, 1'b1);
    applyStimulus(32'h33333333, 1'b0, 1'b1);
    applyStimulus(32'h44444444, 1'b0, 1'b1);
    checkStatus("err_status", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 32'h55555555;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("err_no_accept", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    pulseStart();
    checkStatus("err_cleared", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Reset right after the third word is accepted must cancel its write.
    applyStimulus(32'hAAAA0000, 1'b0, 1'b1);
    applyStimulus(32'hAAAA0001, 1'b0, 1'b1);
    applyStimulus(32'hAAAA0002, 1'b0, 1'b0);
    reset = 1'b0;
    #2;
    checkStatus("midload_reset", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("midload_we", {31'd0, imem_we}, 32'd0);
    checkOutput("midload_addr", {30'd0, imem_addr}, 32'd0);
    checkOutput("midload_wd", imem_wd, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    idleCycles(2);
    checkStatus("post_reset_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulseStart();
    applyStimulus(32'd1, 1'b0, 1'b1);
    applyStimulus(32'd2, 1'b0, 1'b1);
    applyStimulus(32'd3, 1'b1, 1'b1);
    checkStatus("check_status", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'd6, 1'b0, 1'b0);
    checkStatus("sum_ok", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pulseStart();
    applyStimulus(32'd1, 1'b0, 1'b1);
    applyStimulus(32'd2, 1'b0, 1'b1);
    applyStimulus(32'd3, 1'b1, 1'b1);
    applyStimulus(32'd7, 1'b0, 1'b0);
    checkStatus("sum_bad", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    pulseStart();
    checkStatus("sum_err_cleared", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
`endif

    idleCycles(3);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, default 8, word-address width of the instruction memory (2**ADDR_W words).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  one-cycle request to begin a load session.
REQ-005 Port: in_valid  input  1  upstream word valid.
REQ-006 Port: in_data  input  32  instruction word.
REQ-007 Port: in_last  input  1  marks final program word of the session.
REQ-008 Port: in_ready  output  1  loader accepts the word this cycle.
REQ-009 Port: imem_we  output  1  instruction-memory write strobe.
REQ-010 Port: imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 Port: imem_wd  output  32  instruction-memory write data.
REQ-012 Port: cpu_reset  output  1  active-high reset driven to the processor.
REQ-013 Port: busy  output  1  high in LOAD or CHECK.
REQ-014 Port: done  output  1  high in DONE.
REQ-015 Port: err  output  1  high in ERR.

Function
REQ-016 States SHALL be IDLE, LOAD, CHECK, DONE, ERR; all outputs are registered.
REQ-017 IDLE: in_ready=0, cpu_reset=1; start -> LOAD with word counter cleared to 0.
REQ-018 LOAD: in_ready=1; a beat is accepted when in_valid and in_ready are both high.
REQ-019 Each accepted beat SHALL produce imem_we=1 with imem_addr=counter and imem_wd=in_data exactly one cycle later; counter increments by 1.
REQ-020 imem_we SHALL be 0 in every cycle not following an accepted beat; imem_addr/imem_wd hold their last values.
REQ-021 Accepted beat with in_last=1 -> CHECK if CHECKSUM_EN is defined, else DONE.
REQ-022 Accepted beat at counter 2**ADDR_W-1 with in_last=0 -> ERR (overflow); the beat is still written, and the counter does not wrap.
REQ-023 in_valid low in LOAD SHALL stall without timeout; counter and state hold.
REQ-024 start in LOAD or CHECK SHALL be ignored.
REQ-025 DONE: cpu_reset=0, in_ready=0; start -> LOAD, re-asserting cpu_reset in the same cycle the state changes.
REQ-026 ERR: cpu_reset=1, in_ready=0, err=1; start -> LOAD with counter cleared and err cleared.
REQ-027 cpu_reset SHALL be 1 in every state except DONE.
REQ-028 in_last is ignored on non-accepted cycles.

Reset
REQ-029 Asserting reset low SHALL asynchronously force: IDLE, counter 0, in_ready=0, imem_we=0, imem_addr=0, imem_wd=0, cpu_reset=1, busy=0, done=0, err=0, checksum accumulator 0.
REQ-030 Reset mid-LOAD SHALL abandon the session; a pending delayed write SHALL NOT be issued.
REQ-031 Reset deassertion SHALL take effect on the first rising clk edge after it.

Configuration
REQ-032 Macro IMEM_LOADER_CHECKSUM_EN: when defined, a 32-bit modulo-2**32 sum of all accepted program words is kept; in CHECK (in_ready=1) the next accepted word is compared with the sum, not written to memory, and equal -> DONE, unequal -> ERR.
REQ-033 Without IMEM_LOADER_CHECKSUM_EN: no accumulator and no CHECK state are present; in_last goes directly to DONE.

Verification
REQ-034 reset low then high, no start, 10 cycles -> cpu_reset=1, in_ready=0, imem_we=0 throughout.
REQ-035 start, then 4 back-to-back words 0x20020005, 0x2003000C, 0x2067FFF7, 0x00E22025 with in_last on the 4th -> imem_we pulses at addr 0..3, each one cycle after acceptance; DONE; cpu_reset falls.
REQ-036 Same stream with in_valid low for 3 cycles between words 2 and 3 -> identical memory writes, no spurious imem_we.
REQ-037 ADDR_W=2, 5 words without in_last -> addresses 0..3 written, ERR after 4th, err=1, cpu_reset=1, 5th beat not accepted.
REQ-038 reset asserted the cycle after accepting word 2 -> no write to addr 2, all outputs at reset values.
REQ-039 With CHECKSUM_EN: words 1, 2, 3 (last) then checksum 6 -> DONE; repeat with checksum 7 -> ERR, err=1; start then clears err.
